// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray code counter slice.
//   DEFAULT_WIDTH : default counter / Gray output width in bits
//   stateT        : counter state machine encoding {IDLE, RUN, STOP}
//   UP / DOWN     : values of the 'up' direction input
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } stateT;

endpackage

// File: rtl/bin_to_gray.sv
// ---------------------------------------------------------------------------
// bin_to_gray
// Purely combinational binary-to-Gray encoder.
// Ports:
//   i_bin  : WIDTH-bit binary input
//   o_gray : WIDTH-bit Gray code, o_gray = i_bin ^ (i_bin >> 1)
// ---------------------------------------------------------------------------
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  // Each Gray bit is the XOR of a binary bit with its next-higher neighbour;
  // the MSB passes straight through because a zero is shifted in above it.
  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// ---------------------------------------------------------------------------
// gray_code_counter
// Up/down binary counter with a registered Gray code output, a small
// IDLE/RUN/STOP run-control state machine, wrap or one-shot terminal
// behaviour, and synchronous load.
//
// Optional feature macro: GRAY_CNT_ERRCHK_EN
//   defined   : a checker flags (sticky until rst) any counting step whose
//               G update does not change exactly one bit
//   undefined : err is tied low and no checker logic exists
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : IDLE/STOP -> RUN
//   halt     : RUN/STOP -> IDLE
//   en       : step qualifier, honoured only in RUN
//   up       : step direction (1 = increment, 0 = decrement)
//   oneshot  : stop at the terminal value instead of wrapping
//   load     : synchronous load of load_val into the binary count
//   load_val : WIDTH-bit binary load value
//   G        : registered Gray code of the binary count (one cycle behind it)
//   busy     : high while in RUN
//   tc       : one-cycle pulse aligned with the G update of a terminal step
//   err      : sticky Gray adjacency error (see macro above)
// ---------------------------------------------------------------------------
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] G,
  output logic             busy,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  stateT            r_state;
  stateT            w_stateNext;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] w_binNext;
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] r_G;
  logic             r_tcPend;
  logic             r_tc;
  logic             w_step;
  logic             w_terminal;
  logic             w_termStep;
  logic             w_holdStep;

  // Single encoder on the binary register; G is this value registered, so
  // G always trails the binary count by exactly one clock.
  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_binToGray (
    .i_bin (r_bin),
    .o_gray(w_gray)
  );

  // Step qualification and terminal detection. A step only happens in RUN
  // with en set and none of load/halt/start active, since all three outrank
  // stepping. A terminal step under oneshot leaves the count where it is.
  always_comb begin
    w_step     = (r_state == RUN) && en && !load && !halt && !start;
    w_terminal = (up == UP) ? (r_bin == ALL_ONES) : (r_bin == '0);
    w_termStep = w_step && w_terminal;
    w_holdStep = w_termStep && oneshot;
  end

  // Next-state logic. halt beats start; load never blocks a state change on
  // its own, it only claims the binary count and suppresses the step.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_stateNext = RUN;
      end
      RUN: begin
        if (halt)            w_stateNext = IDLE;
        else if (w_holdStep) w_stateNext = STOP;
      end
      STOP: begin
        if (halt)       w_stateNext = IDLE;
        else if (start) w_stateNext = RUN;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Next binary count: load wins in any state, otherwise a qualified step
  // moves by one with natural modulo-2^WIDTH wrap.
  always_comb begin
    w_binNext = r_bin;
    if (load) begin
      w_binNext = load_val;
    end else if (w_step && !w_holdStep) begin
      w_binNext = (up == UP) ? (r_bin + BIN_ONE) : (r_bin - BIN_ONE);
    end
  end

  // State, count and output registers. The terminal flag goes through one
  // extra stage so the tc pulse lines up with the G update of that step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bin    <= '0;
      r_G      <= '0;
      r_tcPend <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bin    <= w_binNext;
      r_G      <= w_gray;
      r_tcPend <= w_termStep;
      r_tc     <= r_tcPend;
    end
  end

  assign G    = r_G;
  assign busy = (r_state == RUN);
  assign tc   = r_tc;

`ifdef GRAY_CNT_ERRCHK_EN
  logic             r_stepPend;
  logic             r_err;
  logic [WIDTH-1:0] w_diff;
  logic             w_notAdjacent;

  // The G update for a step arrives one clock after the step, so the new G
  // (w_gray) is compared with the current G (r_G) while r_stepPend is set.
  // Loads and held oneshot steps never set r_stepPend, so their G jumps or
  // non-changes are not judged. Exactly one differing bit means the diff is
  // a nonzero power of two.
  always_comb begin
    w_diff        = w_gray ^ r_G;
    w_notAdjacent = (w_diff == '0) || ((w_diff & (w_diff - BIN_ONE)) != '0);
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stepPend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_stepPend <= w_step && !w_holdStep;
      if (r_stepPend && w_notAdjacent) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_code_counter
// Scoreboard bench for gray_code_counter (WIDTH = 4). Each stimulus cycle
// pushes the outputs expected after that clock edge; a monitor on the
// falling edge pops and compares them. Extra error-checker cases are built
// when GRAY_CNT_ERRCHK_EN is defined.
// ---------------------------------------------------------------------------
module tb_gray_code_counter;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       busy;
    logic       tc;
    logic       err;
    logic       chkB;
    logic [3:0] b;
    string      name;
  } expT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       oneshot = 1'b0;
  logic       load = 1'b0;
  logic [3:0] loadVal = 4'h0;
  logic [3:0] G;
  logic       busy;
  logic       tc;
  logic       err;

  expT sbQ[$];
  int  cycNo = 0;
  int  nVectors = 0;
  int  nMiscompares = 0;
  logic expErr = 1'b0;

  logic [3:0] upGray [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] downGray [5] = '{4'h7, 4'h6, 4'h2, 4'h3, 4'h1};

  gray_code_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .halt    (halt),
    .en      (en),
    .up      (up),
    .oneshot (oneshot),
    .load    (load),
    .load_val(loadVal),
    .G       (G),
    .busy    (busy),
    .tc      (tc),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Cycle counter used to tag each expectation with the edge it belongs to.
  always @(posedge clk) cycNo++;

  function automatic logic [3:0] grayToBin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] grayOf(input logic [3:0] x);
    return x ^ {1'b0, x[3:1]};
  endfunction

  task automatic checkOutput(input expT e);
    logic [3:0] actB;
    nVectors++;
    if (G !== e.g) begin
      nMiscompares++;
      $display("[TB] FAIL %s.G cyc=%0d got=%h want=%h", e.name, e.cyc, G, e.g);
    end
    nVectors++;
    if (busy !== e.busy) begin
      nMiscompares++;
      $display("[TB] FAIL %s.busy cyc=%0d got=%b want=%b", e.name, e.cyc, busy, e.busy);
    end
    nVectors++;
    if (tc !== e.tc) begin
      nMiscompares++;
      $display("[TB] FAIL %s.tc cyc=%0d got=%b want=%b", e.name, e.cyc, tc, e.tc);
    end
    nVectors++;
    if (err !== e.err) begin
      nMiscompares++;
      $display("[TB] FAIL %s.err cyc=%0d got=%b want=%b", e.name, e.cyc, err, e.err);
    end
    if (e.chkB) begin
      actB = grayToBin(G);
      nVectors++;
      if (actB !== e.b) begin
        nMiscompares++;
        $display("[TB] FAIL %s.B cyc=%0d got=%h want=%h", e.name, e.cyc, actB, e.b);
      end
    end
  endtask

  // Monitor: outputs are stable at the falling edge, so every expectation
  // tagged for the current cycle is compared there.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cycNo) begin
      checkOutput(sbQ.pop_front());
    end
  end

  // Drive one cycle of inputs, record the outputs expected after the coming
  // rising edge, then advance just past that edge.
  task automatic applyStimulus(
    input logic iRst, input logic iStart, input logic iHalt, input logic iEn,
    input logic iUp, input logic iOneshot, input logic iLoad, input logic [3:0] iLoadVal,
    input logic [3:0] eG, input logic eBusy, input logic eTc,
    input logic chkB, input logic [3:0] eB, input string nm);
    expT e;
    rst     = iRst;
    start   = iStart;
    halt    = iHalt;
    en      = iEn;
    up      = iUp;
    oneshot = iOneshot;
    load    = iLoad;
    loadVal = iLoadVal;
    e.cyc  = cycNo + 1;
    e.g    = eG;
    e.busy = eBusy;
    e.tc   = eTc;
    e.err  = expErr;
    e.chkB = chkB;
    e.b    = eB;
    e.name = nm;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then start; first G stays 0 until the first step's update.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "reset1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "reset2");
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "start");

    // Full up count with wrap; Gray-to-binary of G must walk 0..15.
    for (int k = 0; k < 16; k++)
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, upGray[k], 1, 0, 1, 4'(k), "upCount");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 1, 4'h0, "wrapTc");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "afterWrap");

    // Load 5 then count down with oneshot into STOP.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 4'h5, 4'h0, 1, 0, 0, 4'h0, "load5");
    for (int k = 0; k < 5; k++)
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 4'h0, downGray[k], 1, 0, 0, 4'h0, "downStep");
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "termStep");
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 1, 0, 4'h0, "oneshotTc");
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "stopHold");

    // Restart from STOP, two up steps, then load+halt+start together.
    applyStimulus(0, 1, 0, 1, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "restart");
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "stepA");
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h1, 1, 0, 0, 4'h0, "stepB");
    applyStimulus(0, 1, 1, 1, 1, 0, 1, 4'hA, 4'h3, 0, 0, 0, 4'h0, "loadHaltStart");
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'hF, 0, 0, 1, 4'hA, "idleNoStep1");
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'hF, 0, 0, 1, 4'hA, "idleNoStep2");

    // Count down from A to reach G=D, then reset mid-count.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1, 0, 0, 4'h0, "startDown");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'h0, 4'hF, 1, 0, 0, 4'h0, "downToNine");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'h0, 4'hD, 1, 0, 0, 4'h0, "atD");
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "midReset");
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "enNoStart1");
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "enNoStart2");

`ifdef GRAY_CNT_ERRCHK_EN
    // Full down sweep with wrap: err must stay low throughout.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "ecStart");
    for (int k = 1; k <= 16; k++)
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'h0, grayOf(4'((17 - k) % 16)), 1,
                    (k == 2), 0, 4'h0, "ecDown");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "ecDownEnd");

    // One up step, then corrupt the encoder output for its G update.
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, "ecStep");
    force dut.w_gray = 4'h3;
    expErr = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h3, 1, 0, 0, 4'h0, "ecForced");
    release dut.w_gray;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h1, 1, 0, 0, 4'h0, "ecSticky1");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h1, 1, 0, 0, 4'h0, "ecSticky2");
    expErr = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "ecReset");
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, "idleEnd");

    // Give the monitor a bounded window to drain the scoreboard.
    for (int w = 0; w < 10 && sbQ.size() > 0; w++) @(posedge clk);
    #1;
    if (sbQ.size() > 0) begin
      nMiscompares++;
      $display("[TB] FAIL drain pending=%0d want=0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/gray_code_counter.md
GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter and Gray output width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: moves the state machine from IDLE or STOP to RUN.
REQ-005 The block SHALL have port halt, input, 1 bit: moves the state machine from RUN to IDLE.
REQ-006 The block SHALL have port en, input, 1 bit: step qualifier, honoured only in RUN.
REQ-007 The block SHALL have port up, input, 1 bit: step direction, 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port oneshot, input, 1 bit: when 1, the counter stops at the terminal value instead of wrapping.
REQ-009 The block SHALL have port load, input, 1 bit, and port load_val, input, WIDTH bits: synchronous load of a binary value.
REQ-010 The block SHALL have port G, output, WIDTH bits: registered Gray code of the internal binary count, feeding the Gray-to-binary stage.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-012 The block SHALL have port tc, output, 1 bit: single-cycle pulse marking a terminal step.
REQ-013 The block SHALL have port err, output, 1 bit: sticky Gray-adjacency error flag (see Configuration).

Function
REQ-014 The block SHALL hold a WIDTH-bit binary count bin and SHALL drive G = bin ^ (bin >> 1), registered, so that G changes exactly one cycle after the qualifying edge.
REQ-015 The state machine SHALL have states IDLE, RUN and STOP.
REQ-016 The state transitions SHALL be: IDLE->RUN on start; RUN->IDLE on halt; RUN->STOP on an oneshot terminal step; STOP->RUN on start; STOP->IDLE on halt.
REQ-017 A qualified step SHALL be defined as state RUN and en=1 with no load, halt or start active in that cycle.
REQ-018 Per-cycle priority SHALL be rst > load > halt > start > step.
REQ-019 load SHALL set bin = load_val in any state, without changing the state and without a tc pulse.
REQ-020 A terminal step SHALL be defined as (up=1 and bin = all-ones) or (up=0 and bin = 0).
REQ-021 On a terminal step with oneshot=0, bin SHALL wrap modulo 2^WIDTH and the state SHALL stay RUN.
REQ-022 On a terminal step with oneshot=1, bin SHALL be held and the state SHALL go to STOP.
REQ-023 tc SHALL pulse for one cycle, aligned with the G update of the terminal step, in both the wrap and oneshot cases.
REQ-024 In IDLE and STOP, bin and G SHALL hold and tc SHALL be 0.
REQ-025 Every qualified step SHALL change exactly one bit of G, including at the wrap.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set state=IDLE, bin=0, G=0, busy=0, tc=0 and err=0, overriding all other inputs, including mid-count.
REQ-027 After reset is released, the counter SHALL require a start pulse before any stepping occurs.

Configuration
REQ-028 When macro GRAY_CNT_ERRCHK_EN is defined, the block SHALL compare each new G with the previous G on every qualified step and SHALL set err (sticky until rst) if the Hamming distance is not 1.
REQ-029 When GRAY_CNT_ERRCHK_EN is defined, load cycles SHALL be excluded from the err check.
REQ-030 When GRAY_CNT_ERRCHK_EN is undefined, err SHALL be tied to 0 and no checker logic SHALL be present.

Structure
REQ-031 Shared package gray_pkg SHALL hold the default WIDTH constant, the state enum {IDLE, RUN, STOP} and the direction constants UP=1, DOWN=0.
REQ-032 The Gray encoding SHALL be implemented in one combinational sub-module, bin_to_gray, instantiated once on the bin register output.

Verification
REQ-033 The bench SHALL cover: rst, start, en=1, up=1, oneshot=0 for 16 cycles -> G = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0, with tc=1 only on the 8->0 cycle.
REQ-034 The bench SHALL cover: load_val=5, load, then up=0 stepping to 0 with oneshot=1 -> G = 7,6,2,3,1,0 and then holds at 0, tc pulses once, state STOP, busy=0.
REQ-035 The bench SHALL cover: load, halt and start asserted together with en=1 in RUN -> bin = load_val, state IDLE, no step taken.
REQ-036 The bench SHALL cover: rst asserted mid-count at G=D -> next cycle G=0, busy=0, tc=0, err=0; en alone then causes no step.
REQ-037 The bench SHALL cover: all 16 G outputs passed through the Gray-to-binary stage -> B equals the expected binary sequence 0..15.
REQ-038 The bench SHALL cover, with GRAY_CNT_ERRCHK_EN defined: a full up and down sweep -> err stays 0; a forced two-bit G change -> err=1 and stays 1 until rst.
